// File: rtl/adc_paddle_ctrl.sv
// Periodic joystick-X ADC sequencer: request, wait for done with timeout, scale to a clamped paddle_x.
// Optional build macro PADDLE_AVG_EN scales the mean of a 4-sample window instead of the raw result.
module adc_paddle_ctrl #(
    parameter int          SAMPLE_DIV   = 50000,
    parameter int          TIMEOUT      = 1024,
    parameter logic [2:0]  ADC_CHAN     = 3'd0,
    parameter logic [7:0]  PADDLE_MAX   = 8'd127,
    parameter logic [7:0]  PADDLE_RESET = 8'd64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_start,
    output logic [2:0]  adc_chan,
    input  logic        adc_done,
    input  logic [11:0] adc_result,
    output logic [7:0]  paddle_x,
    output logic        paddle_valid,
    output logic        timeout_err
);
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TO_W   = $clog2(TIMEOUT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_PROCESS   = 3'd4;

    logic [2:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [11:0]       sample;
    logic [7:0]        scaled;
    logic [7:0]        clamped;

    assign adc_start = (state == S_START);
    assign adc_chan  = ADC_CHAN;

`ifdef PADDLE_AVG_EN
    // Window holds the three previous results; the fourth slot is the sample being processed.
    logic [11:0] win [3];
    logic [13:0] sum;
    logic        sum_unused;

    assign sum        = 14'(sample) + 14'(win[0]) + 14'(win[1]) + 14'(win[2]);
    assign scaled     = {1'b0, sum[13:7]};
    assign sum_unused = ^sum[6:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win[0] <= 12'd2048;
            win[1] <= 12'd2048;
            win[2] <= 12'd2048;
        end else if (state == S_PROCESS) begin
            win[0] <= sample;
            win[1] <= win[0];
            win[2] <= win[1];
        end
    end
`else
    logic sample_unused;

    assign scaled        = {1'b0, sample[11:5]};
    assign sample_unused = ^sample[4:0];
`endif

    assign clamped = (scaled > PADDLE_MAX) ? PADDLE_MAX : scaled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            to_cnt       <= '0;
            sample       <= '0;
            paddle_x     <= PADDLE_RESET;
            paddle_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            paddle_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state    <= S_WAIT_TICK;
                        tick_cnt <= '0;
                    end
                end
                S_WAIT_TICK: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (tick_cnt == TICK_LAST) begin
                        state <= S_START;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_START: begin
                    state  <= S_WAIT_DONE;
                    to_cnt <= '0;
                end
                S_WAIT_DONE: begin
                    // A done arriving on the last timeout cycle still wins.
                    if (adc_done) begin
                        sample <= adc_result;
                        state  <= S_PROCESS;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= enable ? S_WAIT_TICK : S_IDLE;
                        tick_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_PROCESS: begin
                    paddle_x     <= clamped;
                    paddle_valid <= 1'b1;
                    state        <= enable ? S_WAIT_TICK : S_IDLE;
                    tick_cnt     <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
